// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the matching receiver.
//
// Contents:
//   D           clock cycles per bit, round(27 MHz / 115 200) = 234
//   L           width of the bit-period counter (2^L > D-1)
//   FRAME_BITS  bits per frame: 10 for 8N1, 11 for 8E1
//   uart_state_e  line-protocol state shared by both ends
//
// Configuration macro: TX_PARITY_EN selects the 8E1 frame (even parity bit
// between the data bits and the stop bit). Undefined gives 8N1.

package uart_pkg;

  localparam int unsigned D = 234;
  localparam int unsigned L = 8;

`ifdef TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: a free-running modulo-Div counter used to pace each bit
// on the serial line. Shared with the receiver.
//
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset, counter to 0
//   clear   synchronous restart from 0 (takes priority over enable)
//   enable  advance the counter this cycle
//   tick    high while the counter sits at Div-1, i.e. the last cycle of a bit

module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned Div   = D,
  parameter int unsigned Width = L
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [Width-1:0] Last = Width'(Div - 1);

  logic [Width-1:0] count_q, count_d;

  assign tick = (count_q == Last);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tick ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/transmit.sv
// UART transmitter: sends one byte per frame, LSB first, at 115 200 bit/s
// from a 27 MHz clock. Frame is start(0), 8 data bits, [even parity], stop(1).
// Bytes are taken over a ready/valid handshake so a FIFO can stream frames
// back to back with a single idle cycle between them.
//
// Ports:
//   i_clk    system clock, 27 MHz
//   i_rst    synchronous active-high reset; aborts any frame in flight
//   i_data   byte to send, sampled only on the accept cycle
//   i_valid  host offers i_data
//   o_ready  transmitter idle and able to accept (decoded from state)
//   o_tx     serial line, idles high (registered)
//   o_busy   frame in progress, always !o_ready
//   o_done   one-cycle pulse on the cycle the stop bit has completed
//
// Configuration macro: TX_PARITY_EN inserts an even-parity bit before the
// stop bit (8E1, 11 bit periods per frame). Undefined gives 8N1.

module transmit
  import uart_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic        tx_q,    tx_d;
  logic        done_q,  done_d;
  logic        accept;
  logic        tick;

`ifdef TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  assign accept = i_valid && (state_q == StIdle);

  uart_bit_timer #(
    .Div   (D),
    .Width (L)
  ) u_bit_timer (
    .clk    (i_clk),
    .rst    (i_rst),
    .clear  (accept),
    .enable (state_q != StIdle),
    .tick   (tick)
  );

  // Next-state logic: the timer tick marks the last cycle of every bit.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef TX_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          shift_d = i_data;
          cnt_d   = '0;
          state_d = StStart;
`ifdef TX_PARITY_EN
          parity_d = ^i_data;
`endif
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (cnt_q == 3'd7) begin
            cnt_d = '0;
`ifdef TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StParity: begin
`ifdef TX_PARITY_EN
        if (tick) begin
          state_d = StStop;
        end
`else
        // Unreachable without parity; recover to idle.
        state_d = StIdle;
`endif
      end
      StStop: begin
        if (tick) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Line level is computed from the next state so o_tx changes on the same
  // edge as the state register, e.g. it falls on the edge after the accept.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign o_ready = (state_q == StIdle);
  assign o_busy  = ~o_ready;
  assign o_tx    = tx_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_transmit.sv
// Self-checking bench for transmit. A reference model holds the expected
// line level for every remaining cycle of the current frame in a queue; an
// independent mid-bit sampling receiver decodes the line and checks bytes.

module tb_transmit;

  localparam int BIT = 234;
`ifdef TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, tx, busy, done;

  transmit dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_data  (data),
    .i_valid (valid),
    .o_ready (ready),
    .o_tx    (tx),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  bit         line_q[$];
  logic [7:0] exp_bytes[$];
  bit [10:0]  fb;
  int         m_accepts = 0;
  bit         m_idle = 1'b1;
  bit         m_rst;
  bit         exp_tx = 1'b1;
  bit         exp_done = 1'b0;

  // Loopback receiver state.
  bit         rx_on = 1'b0;
  int         rx_t;
  int         rx_k;
  bit [10:0]  rx_frame;
  logic [7:0] rx_byte;
  bit         rx_err;
  int         rx_decoded = 0;

  always @(posedge clk) begin
    m_rst = rst;
    if (rst) begin
      // A frame cut short by reset is never delivered.
      if (line_q.size() != 0 && exp_bytes.size() != 0) void'(exp_bytes.pop_back());
      line_q.delete();
      exp_tx   = 1'b1;
      exp_done = 1'b0;
    end else if (line_q.size() == 0) begin
      exp_done = 1'b0;
      if (valid) begin
        fb    = '0;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1+i] = data[i];
`ifdef TX_PARITY_EN
        fb[9]  = ^data;
        fb[10] = 1'b1;
`else
        fb[9]  = 1'b1;
`endif
        for (int k = 0; k < NBITS; k++)
          for (int c = 0; c < BIT; c++) line_q.push_back(fb[k]);
        exp_bytes.push_back(data);
        m_accepts++;
      end
      exp_tx = (line_q.size() != 0) ? line_q[0] : 1'b1;
    end else begin
      void'(line_q.pop_front());
      exp_done = (line_q.size() == 0);
      exp_tx   = exp_done ? 1'b1 : line_q[0];
    end
    m_idle = (line_q.size() == 0);

    #1;
    check_eq("tx", tx, exp_tx);
    check_eq("ready", ready, m_idle);
    check_eq("busy", busy, !m_idle);
    check_eq("done", done, exp_done);

    if (m_rst) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx == 1'b0) begin
        rx_on = 1'b1;
        rx_t  = 0;
      end
    end else begin
      rx_t++;
      if (rx_t >= BIT / 2 && (rx_t - BIT / 2) % BIT == 0) begin
        rx_k = (rx_t - BIT / 2) / BIT;
        rx_frame[rx_k] = tx;
        if (rx_k == NBITS - 1) begin
          rx_on   = 1'b0;
          rx_byte = rx_frame[8:1];
          rx_err  = (rx_frame[0] != 1'b0) || (rx_frame[NBITS-1] != 1'b1);
`ifdef TX_PARITY_EN
          if (rx_frame[9] != ^rx_byte) rx_err = 1'b1;
`endif
          rx_decoded++;
          check_eq("rx_err", rx_err, 1'b0);
          check_eq("rx_pending", exp_bytes.size() != 0, 1'b1);
          if (exp_bytes.size() != 0) check_eq("rx_byte", rx_byte, exp_bytes.pop_front());
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 3 * NBITS * BIT && !m_idle; i++) begin
      @(negedge clk);
      data = 8'($urandom);
    end
    check_eq("idle_timeout", m_idle, 1'b1);
  endtask

  // Offer a byte and wait for the model to see it accepted; keep leaves
  // i_valid high so the next call streams back to back.
  task automatic send_byte(input logic [7:0] b, input bit keep);
    int start;
    start = m_accepts;
    @(negedge clk);
    valid = 1'b1;
    data  = b;
    for (int i = 0; i < 3 * NBITS * BIT && m_accepts == start; i++) @(negedge clk);
    check_eq("accept_timeout", m_accepts != start, 1'b1);
    if (!keep) begin
      valid = 1'b0;
      data  = 8'($urandom);
    end
  endtask

  int n_sent    = 0;
  int n_aborted = 0;
  int k;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle line with no valid.
    repeat (5000) begin
      @(negedge clk);
      data = 8'($urandom);
    end

    send_byte(8'h55, 1'b0); n_sent++;
    wait_idle();

    // Back to back with valid held high.
    send_byte(8'h00, 1'b1); n_sent++;
    send_byte(8'hFF, 1'b0); n_sent++;
    wait_idle();

    // Data changes during the frame are ignored.
    send_byte(8'hA3, 1'b0); n_sent++;
    data = 8'h5C;
    repeat (100) @(negedge clk);
    wait_idle();

    // Reset somewhere inside the 4th data bit.
    send_byte(8'h96, 1'b0); n_sent++; n_aborted++;
    k = 937 + int'($urandom_range(0, 230));
    repeat (k - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_tx", tx, 1'b1);
    check_eq("abort_ready", ready, 1'b1);
    repeat (10) @(negedge clk);
    send_byte(8'h3C, 1'b0); n_sent++;
    wait_idle();

    send_byte(8'h07, 1'b0); n_sent++;
    wait_idle();
    send_byte(8'h03, 1'b0); n_sent++;
    wait_idle();

    // Random bytes, random gaps, random streaming.
    for (int i = 0; i < 8; i++) begin
      send_byte(8'($urandom), ($urandom_range(0, 1) == 1));
      n_sent++;
      if (!valid) repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    @(negedge clk);
    valid = 1'b0;
    wait_idle();
    repeat (BIT) @(negedge clk);

    check_eq("rx_all_decoded", exp_bytes.size(), 0);
    check_eq("rx_frames", rx_decoded, n_sent - n_aborted);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/transmit.md
# transmit

UART transmitter: serialises one byte per frame onto a single line at 115 200 bit/s from a 27 MHz clock. Frame format is 8N1, LSB first: one start bit (0), eight data bits, one stop bit (1). It is the transmitting end for the team's UART receiver and uses the same bit period and bit order. A ready/valid handshake on the byte side lets a host or FIFO feed it back-to-back.

## Interface
- D, 234: clock cycles per bit, round(27 MHz / 115 200).
- L, 8: width of the bit-period counter; must satisfy 2^L > D-1.
- i_clk  in  1  system clock, 27 MHz.
- i_rst  in  1  reset, synchronous, active-high.
- i_data  in  8  byte to send; sampled only on an accept cycle.
- i_valid  in  1  host has a byte on i_data.
- o_ready  out  1  transmitter can accept; high only in IDLE.
- o_tx  out  1  serial line; idles high.
- o_busy  out  1  frame in progress; equals !o_ready.
- o_done  out  1  one-cycle pulse when a frame's stop bit completes.

## Operation
- States:
  - IDLE: o_tx=1.
  - START: o_tx=0.
  - DATA: o_tx=shift[0].
  - STOP: o_tx=1.
  - PARITY (only with TX_PARITY_EN).
- Accept: i_valid && o_ready at a rising edge. i_data latches into an 8-bit shift register, r_wait←0, r_cnt←0, state→START.
- r_wait counts 0..D-1 in every non-IDLE state. At r_wait==D-1: r_wait←0 and the state advances.
- START→DATA after D cycles.
- DATA lasts 8 bit periods. At the end of each period: shift←{1'b0, shift[7:1]}, r_cnt←r_cnt+1. After the period in which r_cnt==7: r_cnt←0, state→STOP (or PARITY).
- STOP→IDLE after D cycles. o_done=1 for exactly that transition cycle.
- i_data changes while busy: ignored; the latched byte is sent unmodified.
- i_valid low in IDLE: the line stays 1 indefinitely, with no pulses.
- Reset, including mid-frame: state=IDLE, r_wait=0, r_cnt=0, shift=0, o_tx=1, o_ready=1, o_busy=0, o_done=0. A partial frame is aborted and produces no o_done.

## Timing
- o_tx, o_done: registered.
- o_ready, o_busy: decoded from the state register.
- Accept at edge t: o_tx falls at t+1.
- Each bit is held exactly D cycles.
- Frame length: 10·D = 2340 cycles (11·D with parity).
- o_done is high in the cycle after the last stop-bit cycle; o_ready is high in that same cycle.
- Back-to-back: if i_valid is held high, the next accept occurs in that IDLE cycle. The inter-frame gap is therefore stop bit + 1 cycle of idle (o_tx=1).
- No combinational path from i_valid or i_data to any output.

## Configuration
- TX_PARITY_EN:
  - Defined: a PARITY state is inserted between DATA and STOP, driving o_tx = ^byte (even parity) for D cycles. Frame length becomes 11·D. The receiving end must be configured for 8E1.
  - Undefined: no PARITY state and no parity register; frame is 8N1, 10·D.

## Structure
- Shared uart package:
  - bit-period constants D and L;
  - the state enum (IDLE, START, DATA, PARITY, STOP), shared with the receiver;
  - frame-length constant FRAME_BITS (10 or 11 depending on TX_PARITY_EN).
- Sub-module uart_bit_timer:
  - L-bit counter with clear and enable inputs;
  - outputs tick = (count==D-1);
  - reusable by the receiver.
- The transmitter FSM and shift register live in transmit.

## Test plan
- Reset, then i_valid=0 for 5000 cycles → o_tx=1 throughout, o_ready=1, o_done never pulses.
- Send 0x55 with one accept at t:
  - o_tx=0 over [t+1, t+234];
  - then bits 1,0,1,0,1,0,1,0, each 234 cycles;
  - stop bit 1;
  - o_done at t+2341;
  - a loopback receiver outputs 0x55 with its error flag at 0.
- Back-to-back 0x00 then 0xFF with i_valid held high → second start bit begins exactly 2 cycles after the first stop-bit end (1 idle cycle); the receiver decodes 0x00 then 0xFF.
- Change i_data from 0xA3 to 0x5C during the frame of 0xA3 → line carries 0xA3 (LSB first: 1,1,0,0,0,1,0,1). o_ready=0 throughout the frame.
- Assert i_rst in the 4th data bit → o_tx=1 the next cycle, o_ready=1, no o_done. A subsequent 0x3C sends cleanly.
- With TX_PARITY_EN, send 0x07:
  - parity bit = 1;
  - frame = 2574 cycles;
  - with 0x03, parity bit = 0.
